// File: rtl/shapool_pkg.sv
// Shared definitions for the hashing-pool sequencer: state encoding,
// default geometry and elaboration-time helpers.
package shapool_pkg;

  localparam int POOL_SIZE_DEFAULT           = 8;
  localparam int NONCE_WIDTH_DEFAULT         = 32;
  localparam int DEVICE_CONFIG_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT      = 3'd2,
    ST_FOUND     = 3'd3,
    ST_EXHAUSTED = 3'd4
  } state_t;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input longint unsigned v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/shapool_control_nonce_counter.sv
// Nonce generator: holds the captured device prefix and the batch counter,
// steps by POOL_SIZE and flags the last batch of the partition.
module nonce_counter
  import shapool_pkg::*;
#(
  parameter int POOL_SIZE           = POOL_SIZE_DEFAULT,
  parameter int NONCE_WIDTH         = NONCE_WIDTH_DEFAULT,
  parameter int DEVICE_CONFIG_WIDTH = DEVICE_CONFIG_WIDTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           i_clear,
  input  logic                           i_load,
  input  logic                           i_step,
  input  logic [DEVICE_CONFIG_WIDTH-1:0] i_prefix,
  output logic [NONCE_WIDTH-1:0]         o_nonce,
  output logic                           o_last
);

  localparam int CTR_WIDTH = NONCE_WIDTH - DEVICE_CONFIG_WIDTH;
  // Step size truncated to the counter width; when POOL_SIZE == 2^CTR_WIDTH
  // it wraps to zero, but then the first batch is also the last one.
  localparam logic [CTR_WIDTH-1:0] STEP     = CTR_WIDTH'(POOL_SIZE);
  // Last base counter value: all ones above the pool-index bits.
  localparam logic [CTR_WIDTH-1:0] LAST_CTR = ~(STEP - CTR_WIDTH'(1'b1));

  logic [CTR_WIDTH-1:0]           r_ctr;
  logic [DEVICE_CONFIG_WIDTH-1:0] r_prefix;

  // Counter/prefix registers: clear on job reset, load at job start, step per batch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctr    <= {CTR_WIDTH{1'b0}};
      r_prefix <= {DEVICE_CONFIG_WIDTH{1'b0}};
    end else if (i_clear) begin
      r_ctr    <= {CTR_WIDTH{1'b0}};
      r_prefix <= {DEVICE_CONFIG_WIDTH{1'b0}};
    end else if (i_load) begin
      r_ctr    <= {CTR_WIDTH{1'b0}};
      r_prefix <= i_prefix;
    end else if (i_step) begin
      r_ctr    <= r_ctr + STEP;
    end else begin
      r_ctr    <= r_ctr;
      r_prefix <= r_prefix;
    end
  end

  assign o_nonce = {r_prefix, r_ctr};
  assign o_last  = (r_ctr == LAST_CTR);

endmodule

// File: rtl/shapool_control.sv
// Sequencer between external_io and the hashing pool: issues nonce batches
// across the device partition, latches the first match or flags exhaustion.
module shapool_control
  import shapool_pkg::*;
#(
  parameter int POOL_SIZE           = POOL_SIZE_DEFAULT,
  parameter int NONCE_WIDTH         = NONCE_WIDTH_DEFAULT,
  parameter int DEVICE_CONFIG_WIDTH = DEVICE_CONFIG_WIDTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           core_reset_n,
  input  logic [DEVICE_CONFIG_WIDTH-1:0] device_config,
  output logic                           pool_start,
  output logic [NONCE_WIDTH-1:0]         pool_nonce,
  input  logic                           pool_done,
  input  logic [POOL_SIZE-1:0]           pool_match,
  output logic                           shapool_success,
  output logic [NONCE_WIDTH-1:0]         shapool_result,
  output logic [POOL_SIZE-1:0]           shapool_match_flags,
  output logic                           exhausted,
  output logic                           busy
);

  localparam int CTR_WIDTH = NONCE_WIDTH - DEVICE_CONFIG_WIDTH;

  if (!is_pow2(64'(POOL_SIZE))) begin : g_bad_pool_pow2
    $error("POOL_SIZE must be a power of two");
  end
  if ((CTR_WIDTH < 1) || (CTR_WIDTH > 62) ||
      (64'(POOL_SIZE) > (64'd1 << CTR_WIDTH))) begin : g_bad_pool_fit
    $error("POOL_SIZE must not exceed the nonce counter range");
  end

  state_t                 r_state;
  logic                   r_pool_start;
  logic                   r_success;
  logic                   r_exhausted;
  logic                   r_busy;
  logic [NONCE_WIDTH-1:0] r_result;
  logic [POOL_SIZE-1:0]   r_flags;

  logic                   w_load;
  logic                   w_step;
  logic                   w_last;
  logic                   w_any_match;
  logic [NONCE_WIDTH-1:0] w_nonce;

  assign w_any_match = |pool_match;
  assign w_load      = (r_state == ST_IDLE);
  assign w_step      = (r_state == ST_WAIT) && pool_done && !w_any_match && !w_last;

  nonce_counter #(
    .POOL_SIZE           (POOL_SIZE),
    .NONCE_WIDTH         (NONCE_WIDTH),
    .DEVICE_CONFIG_WIDTH (DEVICE_CONFIG_WIDTH)
  ) u_nonce_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (~core_reset_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_prefix (device_config),
    .o_nonce  (w_nonce),
    .o_last   (w_last)
  );

  // Job sequencing FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_pool_start <= 1'b0;
      r_success    <= 1'b0;
      r_exhausted  <= 1'b0;
      r_busy       <= 1'b0;
      r_result     <= {NONCE_WIDTH{1'b0}};
      r_flags      <= {POOL_SIZE{1'b0}};
    end else if (!core_reset_n) begin
      r_state      <= ST_IDLE;
      r_pool_start <= 1'b0;
      r_success    <= 1'b0;
      r_exhausted  <= 1'b0;
      r_busy       <= 1'b0;
      r_result     <= {NONCE_WIDTH{1'b0}};
      r_flags      <= {POOL_SIZE{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state      <= ST_ISSUE;
          r_pool_start <= 1'b1;
          r_busy       <= 1'b1;
        end
        ST_ISSUE: begin
          r_state      <= ST_WAIT;
          r_pool_start <= 1'b0;
        end
        ST_WAIT: begin
          if (pool_done) begin
            if (w_any_match) begin
              r_result  <= w_nonce;
              r_flags   <= pool_match;
              r_success <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= ST_FOUND;
            end else if (w_last) begin
              r_exhausted <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_EXHAUSTED;
            end else begin
              r_pool_start <= 1'b1;
              r_state      <= ST_ISSUE;
            end
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_FOUND, ST_EXHAUSTED: begin
          r_state <= r_state;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_pool_start <= 1'b0;
          r_success    <= 1'b0;
          r_exhausted  <= 1'b0;
          r_busy       <= 1'b0;
          r_result     <= {NONCE_WIDTH{1'b0}};
          r_flags      <= {POOL_SIZE{1'b0}};
        end
      endcase
    end
  end

  assign pool_start          = r_pool_start;
  assign pool_nonce          = w_nonce;
  assign shapool_success     = r_success;
  assign shapool_result      = r_result;
  assign shapool_match_flags = r_flags;
  assign exhausted           = r_exhausted;
  assign busy                = r_busy;

endmodule

// File: tb/tb_shapool_control.sv
// Self-checking bench for shapool_control: a wide instance (32-bit nonce) and
// a narrow instance (12-bit nonce, two batches per partition) against a
// job-level behavioural model, plus directed literal expectations.
module tb_shapool_control;

  localparam int NB = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       crn   [NB];
  logic [7:0] dc    [NB];
  logic       done  [NB];
  logic [7:0] match [NB];

  logic        a_start, a_succ, a_exh, a_busy;
  logic [31:0] a_nonce, a_res;
  logic [7:0]  a_flags;
  logic        b_start, b_succ, b_exh, b_busy;
  logic [11:0] b_nonce, b_res;
  logic [7:0]  b_flags;

  int checks = 0;
  int errors = 0;

  shapool_control #(.POOL_SIZE(8), .NONCE_WIDTH(32), .DEVICE_CONFIG_WIDTH(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .core_reset_n(crn[0]), .device_config(dc[0]),
    .pool_start(a_start), .pool_nonce(a_nonce), .pool_done(done[0]), .pool_match(match[0]),
    .shapool_success(a_succ), .shapool_result(a_res), .shapool_match_flags(a_flags),
    .exhausted(a_exh), .busy(a_busy)
  );

  shapool_control #(.POOL_SIZE(8), .NONCE_WIDTH(12), .DEVICE_CONFIG_WIDTH(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .core_reset_n(crn[1]), .device_config(dc[1]),
    .pool_start(b_start), .pool_nonce(b_nonce), .pool_done(done[1]), .pool_match(match[1]),
    .shapool_success(b_succ), .shapool_result(b_res), .shapool_match_flags(b_flags),
    .exhausted(b_exh), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (job level) ----------------
  // started: a job has begun; issue: a batch start is being announced;
  // fly: a batch is outstanding in the pool; batch: batch index in partition.
  bit              m_started [NB];
  bit              m_issue   [NB];
  bit              m_fly     [NB];
  bit              m_found   [NB];
  bit              m_exh     [NB];
  longint unsigned m_batch   [NB];
  logic [31:0]     m_prefix  [NB];
  logic [31:0]     m_res     [NB];
  logic [7:0]      m_flags   [NB];
  int              ctr_bits  [NB] = '{24, 4};

  function automatic logic [31:0] exp_nonce(input int i);
    if (!m_started[i]) return 32'h0;
    return (m_prefix[i] << ctr_bits[i]) + 32'(m_batch[i] * 64'd8);
  endfunction

  task automatic model_clear(input int i);
    m_started[i] = 1'b0; m_issue[i] = 1'b0; m_fly[i] = 1'b0;
    m_found[i] = 1'b0; m_exh[i] = 1'b0; m_batch[i] = 64'd0;
    m_prefix[i] = 32'h0; m_res[i] = 32'h0; m_flags[i] = 8'h0;
  endtask

  // Advance the model at each active edge from the inputs seen at that edge.
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (!reset_n || !crn[i]) begin
        model_clear(i);
      end else if (!m_started[i]) begin
        m_started[i] = 1'b1;
        m_prefix[i]  = 32'(dc[i]);
        m_batch[i]   = 64'd0;
        m_issue[i]   = 1'b1;
      end else if (m_issue[i]) begin
        m_issue[i] = 1'b0;
        m_fly[i]   = 1'b1;
      end else if (m_fly[i] && done[i]) begin
        m_fly[i] = 1'b0;
        if (match[i] != 8'h0) begin
          m_found[i] = 1'b1;
          m_res[i]   = exp_nonce(i);
          m_flags[i] = match[i];
        end else if (m_batch[i] == ((64'd1 << ctr_bits[i]) / 64'd8) - 64'd1) begin
          m_exh[i] = 1'b1;
        end else begin
          m_batch[i] = m_batch[i] + 64'd1;
          m_issue[i] = 1'b1;
        end
      end
    end
  end

  task automatic compare_dut(input int i, input string tag, input logic st,
                             input logic [31:0] nonce, input logic succ,
                             input logic [31:0] res, input logic [7:0] flags,
                             input logic exh, input logic bsy);
    check({tag, "_pool_start"}, 32'(st), 32'(m_issue[i]));
    check({tag, "_pool_nonce"}, nonce, exp_nonce(i));
    check({tag, "_success"}, 32'(succ), 32'(m_found[i]));
    check({tag, "_result"}, res, m_found[i] ? m_res[i] : 32'h0);
    check({tag, "_flags"}, 32'(flags), m_found[i] ? 32'(m_flags[i]) : 32'h0);
    check({tag, "_exhausted"}, 32'(exh), 32'(m_exh[i]));
    check({tag, "_busy"}, 32'(bsy), 32'(m_issue[i] | m_fly[i]));
    check({tag, "_succ_exh_excl"}, 32'(succ & exh), 32'h0);
  endtask

  // Compare every cycle on the inactive edge while out of reset.
  always @(negedge clk) begin
    if (reset_n) begin
      compare_dut(0, "a", a_start, a_nonce, a_succ, a_res, a_flags, a_exh, a_busy);
      compare_dut(1, "b", b_start, 32'(b_nonce), b_succ, 32'(b_res), b_flags, b_exh, b_busy);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < NB; i++) begin
      crn[i] = 1'b0; dc[i] = 8'h0; done[i] = 1'b0; match[i] = 8'h0;
    end
    repeat (2) cyc();
    check("rst_busy", 32'(a_busy), 32'h0);
    check("rst_start", 32'(a_start), 32'h0);
    check("rst_nonce", a_nonce, 32'h0);
    check("rst_succ", 32'(a_succ), 32'h0);

    // Match on first batch
    reset_n = 1'b1; dc[0] = 8'hA5; crn[0] = 1'b1;
    cyc();
    check("m1_start", 32'(a_start), 32'h1);
    check("m1_nonce", a_nonce, 32'hA5000000);
    check("m1_busy", 32'(a_busy), 32'h1);
    dc[0] = 8'h5A;
    cyc();
    check("m1_start_pulse", 32'(a_start), 32'h0);
    check("m1_nonce_hold", a_nonce, 32'hA5000000);
    done[0] = 1'b1; match[0] = 8'h10;
    cyc();
    check("m1_succ", 32'(a_succ), 32'h1);
    check("m1_res", a_res, 32'hA5000000);
    check("m1_flags", 32'(a_flags), 32'h10);
    check("m1_busy_end", 32'(a_busy), 32'h0);
    match[0] = 8'hFF;
    cyc();
    check("found_spurious_res", a_res, 32'hA5000000);
    check("found_spurious_flags", 32'(a_flags), 32'h10);
    done[0] = 1'b0; match[0] = 8'h0;

    // Match on third batch
    crn[0] = 1'b0;
    cyc();
    check("jr_succ", 32'(a_succ), 32'h0);
    check("jr_res", a_res, 32'h0);
    crn[0] = 1'b1; dc[0] = 8'hA5;
    cyc();
    check("m3_n0", a_nonce, 32'hA5000000);
    cyc();
    done[0] = 1'b1;
    cyc();
    check("m3_start1", 32'(a_start), 32'h1);
    check("m3_n1", a_nonce, 32'hA5000008);
    done[0] = 1'b0;
    cyc();
    done[0] = 1'b1;
    cyc();
    check("m3_n2", a_nonce, 32'hA5000010);
    done[0] = 1'b0; match[0] = 8'h80;
    cyc();
    match[0] = 8'hFF;
    cyc();
    check("m3_match_nodone_succ", 32'(a_succ), 32'h0);
    check("m3_match_nodone_busy", 32'(a_busy), 32'h1);
    done[0] = 1'b1; match[0] = 8'h01;
    cyc();
    check("m3_res", a_res, 32'hA5000010);
    check("m3_flags", 32'(a_flags), 32'h01);
    done[0] = 1'b0; match[0] = 8'h0;

    // Job reset coincident with a matching pool_done
    crn[0] = 1'b0;
    cyc();
    crn[0] = 1'b1;
    cyc();
    cyc();
    crn[0] = 1'b0; done[0] = 1'b1; match[0] = 8'h04;
    cyc();
    check("jrc_succ", 32'(a_succ), 32'h0);
    check("jrc_busy", 32'(a_busy), 32'h0);
    done[0] = 1'b0; match[0] = 8'h0; crn[0] = 1'b1; dc[0] = 8'h3B;
    cyc();
    check("jrc_restart_nonce", a_nonce, 32'h3B000000);
    done[0] = 1'b1; match[0] = 8'hFF;
    cyc();
    check("issue_spurious_succ", 32'(a_succ), 32'h0);
    check("issue_spurious_busy", 32'(a_busy), 32'h1);
    done[0] = 1'b0; match[0] = 8'h0;
    cyc();

    // Asynchronous reset mid-WAIT
    #2;
    reset_n = 1'b0;
    #1;
    check("ares_busy", 32'(a_busy), 32'h0);
    check("ares_start", 32'(a_start), 32'h0);
    check("ares_nonce", a_nonce, 32'h0);
    check("ares_succ", 32'(a_succ), 32'h0);
    check("ares_exh", 32'(a_exh), 32'h0);
    check("ares_res", a_res, 32'h0);
    cyc();
    reset_n = 1'b1; crn[0] = 1'b0;

    // Exhaustion on the narrow instance
    crn[1] = 1'b1; dc[1] = 8'h3C;
    cyc();
    check("ex_n0", 32'(b_nonce), 32'h3C0);
    check("ex_start0", 32'(b_start), 32'h1);
    cyc();
    done[1] = 1'b1;
    cyc();
    check("ex_n1", 32'(b_nonce), 32'h3C8);
    check("ex_start1", 32'(b_start), 32'h1);
    done[1] = 1'b0;
    cyc();
    done[1] = 1'b1;
    cyc();
    check("ex_exh", 32'(b_exh), 32'h1);
    check("ex_succ", 32'(b_succ), 32'h0);
    check("ex_busy", 32'(b_busy), 32'h0);
    done[1] = 1'b0;
    repeat (3) cyc();
    check("ex_no_third_start", 32'(b_start), 32'h0);
    check("ex_nonce_hold", 32'(b_nonce), 32'h3C8);
    crn[1] = 1'b0;
    cyc();
    check("ex_jr_clear", 32'(b_exh), 32'h0);

    // Randomized traffic on both instances
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < NB; i++) begin
        crn[i]   = ($urandom_range(0, 39) != 0);
        dc[i]    = 8'($urandom);
        done[i]  = ($urandom_range(0, 2) == 0);
        match[i] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h0;
      end
      if (k == 2000) begin
        #2;
        reset_n = 1'b0;
        #1;
        check("rnd_ares_busy", 32'(a_busy | b_busy), 32'h0);
        check("rnd_ares_succ", 32'(a_succ | b_succ), 32'h0);
        cyc();
        reset_n = 1'b1;
      end else begin
        cyc();
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
